// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream_demux4 1-to-4 registered demultiplexer.
// Select encoding matches the ALU result multiplexer: 00=M, 01=J, 10=L, 11=K.
package stream_demux_pkg;

  localparam logic [1:0] SEL_M = 2'b00;
  localparam logic [1:0] SEL_J = 2'b01;
  localparam logic [1:0] SEL_L = 2'b10;
  localparam logic [1:0] SEL_K = 2'b11;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } chan_state_e;

  // One-hot channel vector, bit index equal to the select code.
  function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/stream_demux4_chan_reg.sv
// One-entry holding register with valid/ready handshake for one demux channel.
// Optional macro STREAM_DEMUX_CNT_EN adds a wrapping load counter; without it
// the cnt output is tied to zero and no counter flops exist.
module demux_chan_reg
  import stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             free,
  output logic [CNT_W-1:0] cnt
);

  chan_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Next state: load wins over drain, so a drain+load keeps the slot full.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      CH_EMPTY: begin
        if (load) begin
          state_d = CH_FULL;
          data_d  = ld_data;
        end
      end
      CH_FULL: begin
        if (load) begin
          data_d = ld_data;
        end else if (ready) begin
          state_d = CH_EMPTY;
        end
      end
      default: state_d = CH_EMPTY;
    endcase
  end

  // State and payload registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CH_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid = (state_q == CH_FULL);
  assign data  = data_q;
  assign free  = !valid || ready;

`ifdef STREAM_DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Transfer counter, wraps naturally at 2^CNT_W.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
`else
  assign cnt = '0;
`endif

endmodule

// File: rtl/stream_demux4.sv
// stream_demux4: 8-bit 1-to-4 registered stream demultiplexer, channels J/K/L/M.
// Optional macro STREAM_DEMUX_CNT_EN enables per-channel transfer counters.
module stream_demux4
  import stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] j_data,
  output logic [WIDTH-1:0] k_data,
  output logic [WIDTH-1:0] l_data,
  output logic [WIDTH-1:0] m_data,
  output logic             j_valid,
  output logic             k_valid,
  output logic             l_valid,
  output logic             m_valid,
  input  logic             j_ready,
  input  logic             k_ready,
  input  logic             l_ready,
  input  logic             m_ready,
  output logic [CNT_W-1:0] j_cnt,
  output logic [CNT_W-1:0] k_cnt,
  output logic [CNT_W-1:0] l_cnt,
  output logic [CNT_W-1:0] m_cnt
);

  logic [3:0]       load_vec;
  logic [3:0]       free_vec;
  logic [3:0]       ready_vec;
  logic [3:0]       valid_vec;
  logic [WIDTH-1:0] data_arr [4];
  logic [CNT_W-1:0] cnt_arr  [4];

  // Gather downstream readies into select-code order.
  always_comb begin
    ready_vec        = '0;
    ready_vec[SEL_M] = m_ready;
    ready_vec[SEL_J] = j_ready;
    ready_vec[SEL_L] = l_ready;
    ready_vec[SEL_K] = k_ready;
  end

  assign in_ready = free_vec[in_sel];

  // One-hot load strobe to the addressed channel on an accepted offer.
  always_comb begin
    load_vec = '0;
    if (in_valid && in_ready) begin
      load_vec = sel_onehot(in_sel);
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_chan
    demux_chan_reg #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load_vec[i]),
      .ld_data (in_data),
      .ready   (ready_vec[i]),
      .data    (data_arr[i]),
      .valid   (valid_vec[i]),
      .free    (free_vec[i]),
      .cnt     (cnt_arr[i])
    );
  end

  assign m_data  = data_arr[SEL_M];
  assign j_data  = data_arr[SEL_J];
  assign l_data  = data_arr[SEL_L];
  assign k_data  = data_arr[SEL_K];
  assign m_valid = valid_vec[SEL_M];
  assign j_valid = valid_vec[SEL_J];
  assign l_valid = valid_vec[SEL_L];
  assign k_valid = valid_vec[SEL_K];
  assign m_cnt   = cnt_arr[SEL_M];
  assign j_cnt   = cnt_arr[SEL_J];
  assign l_cnt   = cnt_arr[SEL_L];
  assign k_cnt   = cnt_arr[SEL_K];

endmodule

// File: tb/tb_stream_demux4.sv
// Self-checking bench for stream_demux4: directed steps plus random traffic
// compared against a per-channel queue model (capacity one per channel).
module tb_stream_demux4;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 8;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic [1:0]    in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  j_data, k_data, l_data, m_data;
  logic          j_valid, k_valid, l_valid, m_valid;
  logic          j_ready, k_ready, l_ready, m_ready;
  logic [CW-1:0] j_cnt, k_cnt, l_cnt, m_cnt;

  stream_demux4 #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .j_data   (j_data),
    .k_data   (k_data),
    .l_data   (l_data),
    .m_data   (m_data),
    .j_valid  (j_valid),
    .k_valid  (k_valid),
    .l_valid  (l_valid),
    .m_valid  (m_valid),
    .j_ready  (j_ready),
    .k_ready  (k_ready),
    .l_ready  (l_ready),
    .m_ready  (m_ready),
    .j_cnt    (j_cnt),
    .k_cnt    (k_cnt),
    .l_cnt    (l_cnt),
    .m_cnt    (m_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Channel index = select code: 0=M, 1=J, 2=L, 3=K.
  logic [W-1:0] mq [4][$];
  int unsigned  mcnt [4];
  int unsigned  n_pass  = 0;
  int unsigned  n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_cnt(input int unsigned c);
`ifdef STREAM_DEMUX_CNT_EN
    return mcnt[c] % (32'd1 << CW);
`else
    return 32'd0;
`endif
  endfunction

  task automatic check_outs(input string tag);
    logic [W-1:0]  od [4];
    logic          ov [4];
    logic [CW-1:0] oc [4];
    od[0] = m_data;  od[1] = j_data;  od[2] = l_data;  od[3] = k_data;
    ov[0] = m_valid; ov[1] = j_valid; ov[2] = l_valid; ov[3] = k_valid;
    oc[0] = m_cnt;   oc[1] = j_cnt;   oc[2] = l_cnt;   oc[3] = k_cnt;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("%s_ch%0d_valid", tag, c), {31'd0, ov[c]}, {31'd0, mq[c].size() != 0});
      if (mq[c].size() != 0)
        chk($sformatf("%s_ch%0d_data", tag, c), {24'd0, od[c]}, {24'd0, mq[c][0]});
      chk($sformatf("%s_ch%0d_cnt", tag, c), {24'd0, oc[c]}, exp_cnt(c));
    end
  endtask

  // One clock of traffic: r[c] is the downstream ready of channel c.
  task automatic step(input string tag, input logic v, input logic [1:0] s,
                      input logic [W-1:0] d, input logic [3:0] r);
    logic exp_rdy;
    @(negedge clk);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    m_ready  = r[0];
    j_ready  = r[1];
    l_ready  = r[2];
    k_ready  = r[3];
    #1;
    exp_rdy = (mq[s].size() == 0) || r[s];
    chk({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, exp_rdy});
    @(posedge clk);
    for (int c = 0; c < 4; c++)
      if (mq[c].size() != 0 && r[c]) void'(mq[c].pop_front());
    if (v && exp_rdy) begin
      mq[s].push_back(d);
      mcnt[s]++;
    end
    #1;
    check_outs(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    in_sel   = 2'b01;
    {k_ready, l_ready, j_ready, m_ready} = 4'hF;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      mq[c].delete();
      mcnt[c] = 0;
    end
    chk("rst_m_data", {24'd0, m_data}, 32'd0);
    chk("rst_j_data", {24'd0, j_data}, 32'd0);
    chk("rst_l_data", {24'd0, l_data}, 32'd0);
    chk("rst_k_data", {24'd0, k_data}, 32'd0);
    check_outs("rst");
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_sel   = '0;
    {k_ready, l_ready, j_ready, m_ready} = 4'hF;
    repeat (2) @(posedge clk);
    do_reset();

    // Routing: each word lands on its channel, visible one cycle, then drains.
    step("route_m", 1'b1, 2'b00, 8'h11, 4'hF);
    chk("route_m_data", {24'd0, m_data}, 32'h11);
    step("route_j", 1'b1, 2'b01, 8'h22, 4'hF);
    chk("route_j_data", {24'd0, j_data}, 32'h22);
    chk("route_m_gone", {31'd0, m_valid}, 32'd0);
    step("route_l", 1'b1, 2'b10, 8'h33, 4'hF);
    chk("route_l_data", {24'd0, l_data}, 32'h33);
    step("route_k", 1'b1, 2'b11, 8'h44, 4'hF);
    chk("route_k_data", {24'd0, k_data}, 32'h44);
    step("route_idle", 1'b0, 2'b00, 8'h00, 4'hF);

    // Backpressure on K.
    step("bp_k1", 1'b1, 2'b11, 8'h5A, 4'b0111);
    step("bp_k2", 1'b1, 2'b11, 8'h5B, 4'b0111);
    chk("bp_k_held", {24'd0, k_data}, 32'h5A);
    @(negedge clk);
    #1;
    chk("bp_stalled_ready", {31'd0, in_ready}, 32'd0);
    step("bp_release", 1'b1, 2'b11, 8'h5B, 4'hF);
    chk("bp_k_new", {24'd0, k_data}, 32'h5B);
    chk("bp_k_valid", {31'd0, k_valid}, 32'd1);

    // Independence: K stalled and full, J still accepted.
    step("ind_k", 1'b1, 2'b11, 8'h5C, 4'b0111);
    step("ind_j", 1'b1, 2'b01, 8'h6D, 4'b0111);
    chk("ind_j_data", {24'd0, j_data}, 32'h6D);
    chk("ind_k_data", {24'd0, k_data}, 32'h5B);
    step("ind_drain", 1'b0, 2'b00, 8'h00, 4'hF);

    // Throughput: back-to-back words to L.
    for (int i = 0; i < 16; i++)
      step("tput", 1'b1, 2'b10, 8'(8'hA0 + i), 4'hF);
    step("tput_idle", 1'b0, 2'b10, 8'h00, 4'hF);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step("rnd", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           8'($urandom), 4'($urandom));

    // Counter wrap on M.
    do_reset();
    for (int i = 0; i < 257; i++)
      step("cnt", 1'b1, 2'b00, 8'(i), 4'hF);
`ifdef STREAM_DEMUX_CNT_EN
    chk("cnt_m_wrap", {24'd0, m_cnt}, 32'd1);
`else
    chk("cnt_m_tied", {24'd0, m_cnt}, 32'd0);
`endif
    chk("cnt_j_zero", {24'd0, j_cnt}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stream_demux4.md
Name: stream_demux4

Overview:
- 8-bit, 1-to-4 registered stream demultiplexer: the distribution-side counterpart of the ALU's 4:1 result multiplexer.
- Routes one input stream (data + 2-bit select) to one of four output channels J/K/L/M.
- Uses the same select encoding as the result mux: 00→M, 01→J, 10→L, 11→K.
- Each channel owns a one-entry holding register with a valid/ready handshake, so a stalled channel never blocks traffic addressed to another channel.

Parameters:
- WIDTH, 8, data width of the input and of every channel.
- CNT_W, 8, width of the per-channel transfer counters (optional feature only).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_data  in  WIDTH  input payload
- in_sel  in  2  destination channel: 00=M, 01=J, 10=L, 11=K
- in_valid  in  1  input offer
- in_ready  out  1  input accepted this cycle when in_valid is also high
- j_data / k_data / l_data / m_data  out  WIDTH  channel payload
- j_valid / k_valid / l_valid / m_valid  out  1  channel holds data
- j_ready / k_ready / l_ready / m_ready  in  1  downstream consumes channel data
- j_cnt / k_cnt / l_cnt / m_cnt  out  CNT_W  accepted-transfer count per channel (optional feature only)

Behaviour:
- Reset (synchronous, rst_n=0 at a clk edge):
  - all *_valid=0, all *_data=0, all *_cnt=0.
  - Reset overrides any transfer in the same cycle; in-flight data is discarded.
- Per-channel state machine, two states:
  - EMPTY (valid=0), FULL (valid=1).
  - EMPTY→FULL on load.
  - FULL→EMPTY on drain (valid & ready) with no load.
  - FULL→FULL on drain with simultaneous load; the register takes the new data.
  - FULL with no drain holds its data stable, valid held high.
- Input acceptance:
  - in_ready = !valid[sel] | ready[sel], where sel = in_sel.
  - in_ready is combinational from in_sel, channel state and the downstream ready of the selected channel only.
  - Load condition: in_valid & in_ready; the selected register captures in_data at that edge.
- Latency and throughput:
  - Latency 1 cycle: data accepted at edge N is visible on ch_data/ch_valid after edge N.
  - Throughput 1 transfer/cycle when the downstream holds ready=1, including back-to-back transfers to the same channel.
- Independence:
  - Non-selected channels drain independently in the same cycle as an accept to another channel.
  - A FULL, stalled channel forces in_ready=0 only while in_sel addresses it.
- in_sel and in_data may change freely while in_valid=0. While in_valid=1 and in_ready=0 the upstream must hold them stable (standard valid/ready rule). The block does not check this.
- No reordering within a channel. Ordering across channels is not guaranteed.

Optional Feature:
- Macro STREAM_DEMUX_CNT_EN.
- Defined:
  - Each channel has a CNT_W-bit counter that increments on every load into that channel.
  - Counters wrap from 2^CNT_W−1 to 0 and are cleared by reset.
- Undefined:
  - The *_cnt ports still exist and are tied to 0.
  - No counter flops are synthesised.

Decomposition:
- Shared package stream_demux_pkg:
  - select localparams SEL_M=2'b00, SEL_J=2'b01, SEL_L=2'b10, SEL_K=2'b11, matching the result-mux encoding.
  - default WIDTH.
- Sub-module demux_chan_reg, instantiated 4×:
  - inputs: load, ld_data, ready.
  - outputs: data, valid, free (= !valid | ready), plus the counter under the macro.
- Top level:
  - decodes in_sel into a one-hot load vector and muxes free[] to produce in_ready.

Test Plan:
- Reset: drive rst_n=0 with in_valid=1, in_data=8'hAA → after the edge every *_valid=0, *_data=0, *_cnt=0. in_ready=1 once rst_n=1.
- Routing: send 8'h11/00, 8'h22/01, 8'h33/10, 8'h44/11 with all readies=1 → m_data=11, j_data=22, l_data=33, k_data=44, each valid for exactly 1 cycle, one cycle after its accept.
- Backpressure: k_ready=0, send 8'h5A to K then 8'h5B to K → in_ready=0 on the second offer, k_data stays 5A. Raise k_ready → 5A drains, 5B loads on the same edge, k_valid stays 1.
- Independence: k_ready=0 with K full, then offer to J → accepted immediately, j_data valid next cycle, K unchanged.
- Throughput: 16 back-to-back words to L with l_ready=1 → in_ready=1 every cycle and the output sequence matches the input with no gaps.
- Counters (macro defined): 257 transfers to M → m_cnt=1 (wrap), other counters 0. With the macro undefined, all *_cnt stay 0.
